midi_router_core: RTL and testbench

Central switching stage between the per-port MIDI receivers and transmitters of the router. Scans all ports' RX FIFOs round-robin, parses MIDI framing (status lengths, running status, SysEx, real-time), and forwards each byte to every destination port enabled in the source's route mask. Locks onto one source for a complete message so messages from different sources are never interleaved on an output. Drives the `txdv`/`txdata`/`txcurport` bundle consumed by the `midi_port` array.

---
 rtl/midi_router_core.sv | 234 +++++++++++++++++++++++
 tb/tb_midi_router_core.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/midi_router_core.sv
// midi_router_core
//
// Central switching stage of the MIDI router. Scans every port's RX FIFO
// round-robin, follows MIDI framing (message lengths, running status,
// SysEx, real-time bytes), and copies each byte to every destination port
// named in the source's route mask. While a message is in progress the core
// stays locked to its source, so messages from different sources never
// interleave on an output.
//
// Ports:
//   clk        system clock
//   rst        synchronous active-high reset
//   rx_empty   [PORTS]          per-port RX FIFO empty
//   rx_rden    [PORTS]          per-port RX FIFO read strobe (one-hot, one cycle)
//   rxdata     [PORTS*8]        per-port RX FIFO data, valid the cycle after rx_rden
//   tx_full    [PORTS]          per-port TX not ready
//   route      [PORTS*PORTS]    destination mask of source s at [s*PORTS +: PORTS]
//   txdv       [PORTS]          one-cycle write strobe per destination
//   txdata     [PORTS*8]        byte per destination, qualified by txdv
//   txcurport  [PORTS*4]        source port number per destination, qualified by txdv

module midi_router_core #(
    parameter int PORTS   = 8,
    parameter int TIMEOUT = 24000
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [PORTS-1:0]         rx_empty,
    output logic [PORTS-1:0]         rx_rden,
    input  logic [PORTS*8-1:0]       rxdata,
    input  logic [PORTS-1:0]         tx_full,
    input  logic [PORTS*PORTS-1:0]   route,
    output logic [PORTS-1:0]         txdv,
    output logic [PORTS*8-1:0]       txdata,
    output logic [PORTS*4-1:0]       txcurport
);

    localparam logic [2:0] S_SCAN  = 3'd0;
    localparam logic [2:0] S_READ  = 3'd1;
    localparam logic [2:0] S_LATCH = 3'd2;
    localparam logic [2:0] S_SEND  = 3'd3;
    localparam logic [2:0] S_HOLD  = 3'd4;

    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    logic [2:0]       state;
    logic [3:0]       ptr;
    logic [3:0]       src;
    logic [7:0]       byte_r;
    logic             locked;
    logic             sysex;
    logic [1:0]       remaining;
    logic [TW-1:0]    timer;
    logic [7:0]       run_status [16];

    // Per-port views padded to 16 entries so a 4-bit port number always
    // indexes them exactly; padding ports look permanently empty.
    logic [15:0]      empty_ext;
    logic [7:0]       rx_bytes [16];
    logic [PORTS-1:0] route_of [16];

    logic             scan_hit;
    logic [3:0]       scan_sel;
    logic [7:0]       rx_byte;
    logic [PORTS-1:0] send_mask;

    // Port number base+off, wrapped modulo PORTS.
    function automatic logic [3:0] port_at(input logic [3:0] base, input int off);
        logic [4:0] s;
        s = {1'b0, base} + 5'(off);
        if (s >= 5'(PORTS))
            s = s - 5'(PORTS);
        return s[3:0];
    endfunction

    function automatic logic [3:0] next_port(input logic [3:0] p);
        if (int'(p) >= PORTS - 1)
            return 4'd0;
        return p + 4'd1;
    endfunction

    always_comb begin
        empty_ext = '1;
        empty_ext[PORTS-1:0] = rx_empty;
        for (int p = 0; p < 16; p++) begin
            rx_bytes[p] = 8'h00;
            route_of[p] = '0;
        end
        for (int p = 0; p < PORTS; p++) begin
            rx_bytes[p] = rxdata[p*8 +: 8];
            route_of[p] = route[p*PORTS +: PORTS];
        end
    end

    // Walk the offsets from the far end back towards ptr so the last hit
    // written is the nearest non-empty port at or after ptr.
    always_comb begin
        scan_hit = 1'b0;
        scan_sel = ptr;
        for (int i = PORTS - 1; i >= 0; i--) begin
            if (!empty_ext[port_at(ptr, i)]) begin
                scan_hit = 1'b1;
                scan_sel = port_at(ptr, i);
            end
        end
    end

    assign rx_byte   = rx_bytes[src];
    assign send_mask = route_of[src];

    for (genvar p = 0; p < PORTS; p++) begin : g_rden
        assign rx_rden[p] = (state == S_READ) && (src == 4'(p));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_SCAN;
            ptr       <= 4'd0;
            src       <= 4'd0;
            byte_r    <= 8'h00;
            locked    <= 1'b0;
            sysex     <= 1'b0;
            remaining <= 2'd0;
            timer     <= '0;
            txdv      <= '0;
            txdata    <= '0;
            txcurport <= '0;
            for (int p = 0; p < 16; p++)
                run_status[p] <= 8'h00;
        end else begin
            txdv <= '0;
            case (state)
                S_SCAN: begin
                    if (scan_hit) begin
                        src   <= scan_sel;
                        state <= S_READ;
                    end
                end

                S_READ: state <= S_LATCH;

                S_LATCH: begin
                    byte_r <= rx_byte;
                    state  <= S_SEND;
                    // Real-time bytes (F8-FF) pass straight through and leave
                    // the framing state untouched.
                    if (rx_byte < 8'hF8) begin
                        if (rx_byte[7]) begin
                            // Any other status byte terminates a SysEx in progress.
                            sysex <= 1'b0;
                            if (rx_byte < 8'hF0) begin
                                run_status[src] <= rx_byte;
                                remaining <= (rx_byte[7:5] == 3'b110) ? 2'd1 : 2'd2;
                                locked    <= 1'b1;
                            end else begin
                                run_status[src] <= 8'h00;
                                case (rx_byte)
                                    8'hF0: begin
                                        sysex     <= 1'b1;
                                        remaining <= 2'd0;
                                        locked    <= 1'b1;
                                    end
                                    8'hF1, 8'hF3: begin
                                        remaining <= 2'd1;
                                        locked    <= 1'b1;
                                    end
                                    8'hF2: begin
                                        remaining <= 2'd2;
                                        locked    <= 1'b1;
                                    end
                                    default: begin
                                        remaining <= 2'd0;
                                        locked    <= 1'b0;
                                    end
                                endcase
                            end
                        end else if (sysex) begin
                            // SysEx payload: forward as is.
                        end else if (remaining != 2'd0) begin
                            remaining <= remaining - 2'd1;
                        end else if (run_status[src] != 8'h00) begin
                            // First data byte of a running-status message.
                            remaining <= (run_status[src][7:5] == 3'b110) ? 2'd0 : 2'd1;
                            locked    <= 1'b1;
                        end else begin
                            // Orphan data byte: consumed without any output.
                            locked <= 1'b0;
                            ptr    <= next_port(src);
                            state  <= S_SCAN;
                        end
                    end
                end

                S_SEND: begin
                    if ((tx_full & send_mask) == '0) begin
                        txdv <= send_mask;
                        for (int d = 0; d < PORTS; d++) begin
                            if (send_mask[d]) begin
                                txdata[d*8 +: 8]    <= byte_r;
                                txcurport[d*4 +: 4] <= src;
                            end
                        end
                        if (locked && (sysex || remaining != 2'd0)) begin
                            timer <= '0;
                            state <= S_HOLD;
                        end else begin
                            locked <= 1'b0;
                            ptr    <= next_port(src);
                            state  <= S_SCAN;
                        end
                    end
                end

                S_HOLD: begin
                    if (!empty_ext[src]) begin
                        state <= S_READ;
                    end else if (timer == TW'(TIMEOUT - 1)) begin
                        // Abandon the unfinished message; running status survives.
                        locked    <= 1'b0;
                        sysex     <= 1'b0;
                        remaining <= 2'd0;
                        ptr       <= next_port(src);
                        state     <= S_SCAN;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end

                default: state <= S_SCAN;
            endcase
        end
    end

endmodule

// File: tb/tb_midi_router_core.sv
// tb_midi_router_core
//
// Directed bench for midi_router_core: models the per-port RX FIFOs and
// records every txdv strobe per destination, then compares the recorded
// byte/source sequences against hand-computed expectations.

module tb_midi_router_core;

    localparam int PORTS   = 8;
    localparam int TIMEOUT = 40;

    logic                   clk = 1'b0;
    logic                   rst;
    logic [PORTS-1:0]       rx_empty;
    logic [PORTS-1:0]       rx_rden;
    logic [PORTS*8-1:0]     rxdata = '0;
    logic [PORTS-1:0]       tx_full;
    logic [PORTS*PORTS-1:0] route;
    logic [PORTS-1:0]       txdv;
    logic [PORTS*8-1:0]     txdata;
    logic [PORTS*4-1:0]     txcurport;

    int checks = 0;
    int errors = 0;

    midi_router_core #(.PORTS(PORTS), .TIMEOUT(TIMEOUT)) dut (
        .clk       (clk),
        .rst       (rst),
        .rx_empty  (rx_empty),
        .rx_rden   (rx_rden),
        .rxdata    (rxdata),
        .tx_full   (tx_full),
        .route     (route),
        .txdv      (txdv),
        .txdata    (txdata),
        .txcurport (txcurport)
    );

    always #5 clk = ~clk;

    // RX FIFO model: the stimulus process owns wp/mem, the read side owns rp.
    int         wp [PORTS] = '{default: 0};
    int         rp [PORTS] = '{default: 0};
    logic [7:0] mem [PORTS][32];

    for (genvar p = 0; p < PORTS; p++) begin : g_empty
        assign rx_empty[p] = (wp[p] == rp[p]);
    end

    always @(posedge clk) begin
        for (int p = 0; p < PORTS; p++) begin
            if (rx_rden[p]) begin
                rxdata[p*8 +: 8] <= mem[p][rp[p] % 32];
                rp[p] <= rp[p] + 1;
            end
        end
    end

    // TX recorder: each entry is {source port, byte}.
    int          rec_cnt [PORTS] = '{default: 0};
    logic [11:0] rec [PORTS][64];
    int          dv_total  = 0;
    logic        rden_bad  = 1'b0;

    always @(negedge clk) begin
        for (int d = 0; d < PORTS; d++) begin
            if (txdv[d]) begin
                rec[d][rec_cnt[d] % 64] <= {txcurport[d*4 +: 4], txdata[d*8 +: 8]};
                rec_cnt[d] <= rec_cnt[d] + 1;
            end
        end
        dv_total <= dv_total + $countones(txdv);
        if (!rst && (($countones(rx_rden) > 1) || ((rx_rden & rx_empty) != '0)))
            rden_bad <= 1'b1;
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic ticks(input int n);
        repeat (n) tick();
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input int port, input logic [7:0] b);
        mem[port][wp[port] % 32] = b;
        wp[port] = wp[port] + 1;
    endtask

    task automatic wait_records(input int d, input int target, input int budget,
                                input string tag);
        int n;
        n = 0;
        while (rec_cnt[d] < target && n < budget) begin
            tick();
            n++;
        end
        checkOutput(tag, 32'(rec_cnt[d]), 32'(target));
    endtask

    task automatic expect_rec(input int d, input int idx, input logic [3:0] port,
                              input logic [7:0] b, input string tag);
        checkOutput(tag, 32'(rec[d][idx % 64]), 32'({port, b}));
    endtask

    task automatic check_outputs_zero(input string tag);
        checkOutput({tag, " txdv"},      32'(txdv),      32'd0);
        checkOutput({tag, " rx_rden"},   32'(rx_rden),   32'd0);
        checkOutput({tag, " txdata"},    32'(txdata),    32'd0);
        checkOutput({tag, " txcurport"}, 32'(txcurport), 32'd0);
    endtask

    initial begin
        int n;
        int base;
        logic [7:0] note [3];
        logic [7:0] rs_seq [5];
        logic [7:0] sx_seq [5];
        note   = '{8'h90, 8'h3C, 8'h64};
        rs_seq = '{8'h90, 8'h3C, 8'h64, 8'h40, 8'h00};
        sx_seq = '{8'hF0, 8'h7E, 8'hF8, 8'h7F, 8'hF7};

        rst     = 1'b1;
        tx_full = '0;
        route   = '0;
        ticks(3);
        check_outputs_zero("reset");
        rst = 1'b0;
        tick();

        // Note on port 0 to ports 1 and 2, with first-byte latency.
        $display("[TB] note on port 0 to ports 1,2");
        route[0*PORTS +: PORTS] = 8'h06;
        for (int i = 0; i < 3; i++) applyStimulus(0, note[i]);
        n = 0;
        while (txdv == '0 && n < 20) begin
            tick();
            n++;
        end
        checkOutput("first byte latency", 32'(n), 32'd4);
        wait_records(1, 3, 100, "port1 count");
        wait_records(2, 3, 100, "port2 count");
        for (int i = 0; i < 3; i++) begin
            expect_rec(1, i, 4'd0, note[i], $sformatf("port1 byte%0d", i));
            expect_rec(2, i, 4'd0, note[i], $sformatf("port2 byte%0d", i));
        end
        checkOutput("port0 untouched", 32'(rec_cnt[0]), 32'd0);

        // Running status on port 3 to port 0.
        $display("[TB] running status on port 3");
        route[3*PORTS +: PORTS] = 8'h01;
        for (int i = 0; i < 5; i++) applyStimulus(3, rs_seq[i]);
        wait_records(0, 5, 200, "running status count");
        for (int i = 0; i < 5; i++)
            expect_rec(0, i, 4'd3, rs_seq[i], $sformatf("running status byte%0d", i));

        // Orphan data byte on port 4 is consumed and dropped.
        $display("[TB] orphan data byte on port 4");
        route[4*PORTS +: PORTS] = 8'hFF;
        base = dv_total;
        applyStimulus(4, 8'h40);
        ticks(30);
        checkOutput("orphan dropped", 32'(dv_total), 32'(base));
        checkOutput("orphan consumed", 32'(rx_empty[4]), 32'd1);

        // Two sources to port 2: whole messages, never interleaved.
        $display("[TB] two sources to port 2");
        route[0*PORTS +: PORTS] = 8'h04;
        route[1*PORTS +: PORTS] = 8'h04;
        base = rec_cnt[2];
        for (int i = 0; i < 3; i++) applyStimulus(0, note[i]);
        applyStimulus(1, 8'h91);
        applyStimulus(1, 8'h40);
        applyStimulus(1, 8'h7F);
        wait_records(2, base + 6, 300, "merge count");
        for (int i = 0; i < 3; i++)
            expect_rec(2, base + i, 4'd0, note[i], $sformatf("merge src0 byte%0d", i));
        expect_rec(2, base + 3, 4'd1, 8'h91, "merge src1 byte0");
        expect_rec(2, base + 4, 4'd1, 8'h40, "merge src1 byte1");
        expect_rec(2, base + 5, 4'd1, 8'h7F, "merge src1 byte2");

        // SysEx with embedded real-time on port 5, competing F8 on port 6.
        $display("[TB] sysex on port 5");
        route[5*PORTS +: PORTS] = 8'h08;
        route[6*PORTS +: PORTS] = 8'h08;
        base = rec_cnt[3];
        for (int i = 0; i < 5; i++) applyStimulus(5, sx_seq[i]);
        applyStimulus(6, 8'hF8);
        wait_records(3, base + 6, 300, "sysex count");
        for (int i = 0; i < 5; i++)
            expect_rec(3, base + i, 4'd5, sx_seq[i], $sformatf("sysex byte%0d", i));
        expect_rec(3, base + 5, 4'd6, 8'hF8, "after sysex release");

        // Unfinished message on port 0 holds the lock until the timeout.
        $display("[TB] timeout on port 0");
        route[0*PORTS +: PORTS] = 8'h02;
        route[1*PORTS +: PORTS] = 8'h01;
        base = rec_cnt[1];
        applyStimulus(0, 8'h90);
        applyStimulus(0, 8'h3C);
        wait_records(1, base + 2, 100, "partial message count");
        base = rec_cnt[0];
        applyStimulus(1, 8'hF8);
        ticks(20);
        checkOutput("locked before timeout", 32'(rec_cnt[0]), 32'(base));
        wait_records(0, base + 1, TIMEOUT + 60, "served after timeout");
        expect_rec(0, base, 4'd1, 8'hF8, "byte after timeout");

        // tx_full on the destination stalls the send.
        $display("[TB] tx_full stall");
        route[2*PORTS +: PORTS] = 8'h10;
        tx_full = 8'h10;
        base = rec_cnt[4];
        applyStimulus(2, 8'hF8);
        ticks(20);
        checkOutput("stalled no txdv", 32'(rec_cnt[4]), 32'(base));
        tx_full = '0;
        wait_records(4, base + 1, 20, "released after stall");
        expect_rec(4, base, 4'd2, 8'hF8, "stalled byte");

        // Reset in the middle of a message.
        $display("[TB] reset mid-message");
        route[0*PORTS +: PORTS] = 8'h02;
        base = rec_cnt[1];
        applyStimulus(0, 8'h90);
        applyStimulus(0, 8'h3C);
        wait_records(1, base + 2, 100, "pre-reset count");
        rst = 1'b1;
        tick();
        check_outputs_zero("mid reset");
        rst = 1'b0;
        tick();
        checkOutput("post reset rx_rden", 32'(rx_rden), 32'd0);
        checkOutput("post reset txdv", 32'(txdv), 32'd0);
        base = dv_total;
        applyStimulus(0, 8'h64);
        ticks(30);
        checkOutput("post reset data dropped", 32'(dv_total), 32'(base));
        checkOutput("post reset data consumed", 32'(rx_empty[0]), 32'd1);

        checkOutput("rx_rden protocol", 32'(rden_bad), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
